// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator for the word-addressed data port of the
// NPC unified memory. Takes one byte-addressed request at a time, converts the
// address to a word index, does read-modify-write for sub-word stores and
// returns extended load data (or an error) on a valid/ready response channel.
//
// Optional build macro: LSU_BOUNDS_CHECK_EN -- when defined, a word index
// >= DEPTH is reported as an error with no memory access.
//
// Ports:
//   clk, rst              clock; synchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_wen, req_size, req_unsigned, req_addr, req_wdata   request fields
//   resp_valid/resp_ready response handshake
//   resp_rdata, resp_err  response payload
//   mem_raddr, mem_rdata  memory read port (combinational read data)
//   mem_waddr, mem_wdata, mem_wen   memory write port
module lsu_mem_master #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned IDX_W = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        mem_wen
);

    typedef enum logic [2:0] {StIdle, StLoad, StRmwRd, StWrite, StResp} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        wen_q, wen_d;
    logic        uns_q, uns_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    logic        fire;
    logic        req_bad;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_ext;
    logic [31:0] merged;
    logic [31:0] word_idx;

    // Parameters only matter to the optional bounds check.
    logic unused_cfg;
    assign unused_cfg = ^{DEPTH, IDX_W};

    assign fire     = req_valid & req_ready;
    assign word_idx = {2'b00, addr_q[31:2]};

    // Request legality, evaluated on the live request fields at fire.
    always_comb begin
        req_bad = 1'b0;
        unique case (req_size)
            2'd0: req_bad = 1'b0;
            2'd1: req_bad = req_addr[0];
            2'd2: req_bad = |req_addr[1:0];
            2'd3: req_bad = 1'b1;
        endcase
`ifdef LSU_BOUNDS_CHECK_EN
        if ({2'b00, req_addr[31:2]} >= DEPTH) begin
            req_bad = 1'b1;
        end
`endif
    end

    // Lane extraction and extension of the captured load word.
    always_comb begin
        byte_v = 8'h00;
        unique case (addr_q[1:0])
            2'd0: byte_v = data_q[7:0];
            2'd1: byte_v = data_q[15:8];
            2'd2: byte_v = data_q[23:16];
            2'd3: byte_v = data_q[31:24];
        endcase
        half_v = addr_q[1] ? data_q[31:16] : data_q[15:0];
        unique case (size_q)
            2'd0:    load_ext = {{24{byte_v[7] & ~uns_q}}, byte_v};
            2'd1:    load_ext = {{16{half_v[15] & ~uns_q}}, half_v};
            default: load_ext = data_q;
        endcase
    end

    // Store data: full word, or the RMW word with one lane replaced.
    always_comb begin
        merged = data_q;
        unique case (size_q)
            2'd0: begin
                unique case (addr_q[1:0])
                    2'd0: merged[7:0]   = wdata_q[7:0];
                    2'd1: merged[15:8]  = wdata_q[7:0];
                    2'd2: merged[23:16] = wdata_q[7:0];
                    2'd3: merged[31:24] = wdata_q[7:0];
                endcase
            end
            2'd1: begin
                if (addr_q[1]) begin
                    merged[31:16] = wdata_q[15:0];
                end else begin
                    merged[15:0] = wdata_q[15:0];
                end
            end
            default: merged = wdata_q;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wen_d   = wen_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (fire) begin
                    addr_d  = req_addr;
                    size_d  = req_size;
                    wen_d   = req_wen;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    err_d   = req_bad;
                    if (req_bad) begin
                        state_d = StResp;
                    end else if (!req_wen) begin
                        state_d = StLoad;
                    end else if (req_size == 2'd2) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRmwRd;
                    end
                end
            end
            StLoad: begin
                data_d  = mem_rdata;
                state_d = StResp;
            end
            StRmwRd: begin
                data_d  = mem_rdata;
                state_d = StWrite;
            end
            StWrite: begin
                state_d = StResp;
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            addr_q  <= 32'h0;
            size_q  <= 2'd0;
            wen_q   <= 1'b0;
            uns_q   <= 1'b0;
            wdata_q <= 32'h0;
            data_q  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wen_q   <= wen_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Outputs are pure functions of state so they hold steady through RESP.
    always_comb begin
        req_ready  = (state_q == StIdle);
        resp_valid = (state_q == StResp);
        resp_err   = resp_valid & err_q;
        resp_rdata = (resp_valid && !err_q && !wen_q) ? load_ext : 32'h0;
        mem_raddr  = (state_q == StIdle) ? 32'h0 : word_idx;
        mem_waddr  = (state_q == StIdle) ? 32'h0 : word_idx;
        mem_wen    = (state_q == StWrite);
        mem_wdata  = mem_wen ? merged : 32'h0;
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_wen;

    lsu_mem_master #(
        .DEPTH(128),
        .IDX_W(7)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wen     (req_wen),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_raddr   (mem_raddr),
        .mem_rdata   (mem_rdata),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_wen     (mem_wen)
    );

    always #5 clk = ~clk;

    // Attached memory: 128 words, upper index bits truncated.
    logic [31:0] mem [128];
    assign mem_rdata = mem[mem_raddr[6:0]];
    always @(posedge clk) begin
        if (mem_wen === 1'b1) mem[mem_waddr[6:0]] <= mem_wdata;
    end

    int wen_cnt = 0;
    always @(posedge clk) begin
        if (mem_wen === 1'b1) wen_cnt <= wen_cnt + 1;
    end

    // Behavioural model: per request, the response and write are computed from
    // the rules up front; a cycle age against the expected latency says when
    // each must be visible.
    bit          m_busy = 1'b0;
    int          m_age = 0;
    int          m_lat = 0;
    logic [31:0] m_idx = 32'h0;
    logic        m_err = 1'b0;
    logic        m_wr = 1'b0;
    logic [31:0] m_rdata = 32'h0;
    logic [31:0] m_wdata = 32'h0;
    logic [31:0] ref_mem [128];
    logic [31:0] m_old, m_v, m_mask;
    int          m_sh;
    bit          m_bad;

    always @(posedge clk) begin
        if (!rst) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_idx = {2'b00, req_addr[31:2]};
                m_sh  = 8 * int'(req_addr[1:0]);
                m_bad = (req_size == 2'd3) || (req_size == 2'd1 && req_addr[0]) ||
                        (req_size == 2'd2 && req_addr[1:0] != 2'd0);
`ifdef LSU_BOUNDS_CHECK_EN
                if (m_idx >= 128) m_bad = 1'b1;
`endif
                m_old   = ref_mem[m_idx[6:0]];
                m_err   = m_bad;
                m_rdata = 32'h0;
                m_wr    = 1'b0;
                m_wdata = 32'h0;
                if (m_bad) begin
                    m_lat = 1;
                end else if (!req_wen) begin
                    m_lat = 2;
                    if (req_size == 2'd0) begin
                        m_v = (m_old >> m_sh) & 32'hFF;
                        if (!req_unsigned && m_v >= 32'h80) m_v = m_v | 32'hFFFF_FF00;
                    end else if (req_size == 2'd1) begin
                        m_v = (m_old >> m_sh) & 32'hFFFF;
                        if (!req_unsigned && m_v >= 32'h8000) m_v = m_v | 32'hFFFF_0000;
                    end else begin
                        m_v = m_old;
                    end
                    m_rdata = m_v;
                end else if (req_size == 2'd2) begin
                    m_lat   = 2;
                    m_wr    = 1'b1;
                    m_wdata = req_wdata;
                end else begin
                    m_lat   = 3;
                    m_wr    = 1'b1;
                    m_mask  = (req_size == 2'd0) ? 32'hFF : 32'hFFFF;
                    m_wdata = (m_old & ~(m_mask << m_sh)) | ((req_wdata & m_mask) << m_sh);
                end
                m_busy = 1'b1;
                m_age  = 1;
            end
        end else if (m_age >= m_lat) begin
            if (resp_ready) m_busy = 1'b0;
        end else begin
            if (m_wr && m_age == m_lat - 1) ref_mem[m_idx[6:0]] = m_wdata;
            m_age = m_age + 1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic exp_rv, exp_wen;
        exp_rv  = m_busy && (m_age >= m_lat);
        exp_wen = m_busy && m_wr && (m_age == m_lat - 1);
        cmp("req_ready", {31'b0, req_ready}, {31'b0, !m_busy});
        cmp("resp_valid", {31'b0, resp_valid}, {31'b0, exp_rv});
        cmp("mem_wen", {31'b0, mem_wen}, {31'b0, exp_wen});
        if (m_busy) begin
            cmp("mem_raddr", mem_raddr, m_idx);
            cmp("mem_waddr", mem_waddr, m_idx);
        end else begin
            cmp("idle_raddr", mem_raddr, 32'h0);
            cmp("idle_waddr", mem_waddr, 32'h0);
            cmp("idle_wdata", mem_wdata, 32'h0);
        end
        if (exp_wen) cmp("mem_wdata", mem_wdata, m_wdata);
        if (exp_rv) begin
            cmp("resp_rdata", resp_rdata, m_rdata);
            cmp("resp_err", {31'b0, resp_err}, {31'b0, m_err});
        end else begin
            cmp("quiet_rdata", resp_rdata, 32'h0);
            cmp("quiet_err", {31'b0, resp_err}, 32'h0);
        end
    endtask

    // Every cycle passes through here; inputs change at posedge + 2.
    task automatic step();
        @(negedge clk);
        if (chk_en) compare_all();
        @(posedge clk);
        #2;
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd, input int hold,
                          output logic [31:0] rd, output logic er, output int lat);
        int n;
        req_wen      = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = wd;
        req_valid    = 1'b1;
        step();
        req_valid = 1'b0;
        n = 1;
        while (resp_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) cmp("resp_timeout", {31'b0, resp_valid}, 32'h1);
        lat = n;
        rd  = resp_rdata;
        er  = resp_err;
        repeat (hold) step();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          wc;

    initial begin
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst    = 1'b1;
        chk_en = 1'b1;
        cmp("rst_req_ready", {31'b0, req_ready}, 32'h1);
        cmp("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        cmp("rst_mem_wen", {31'b0, mem_wen}, 32'h0);
        step();

        do_req(1'b1, 2'd2, 1'b0, 32'h0, 32'h1234_5678, 0, rd, er, lat);
        wc = wen_cnt;
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, rd, er, lat);
        cmp("sw_lat", 32'(lat), 32'd2);
        cmp("sw_wen_cycles", 32'(wen_cnt - wc), 32'd1);
        cmp("sw_mem4", mem[4], 32'hDEAD_BEEF);

        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, rd, er, lat);
        cmp("lw_data", rd, 32'hDEAD_BEEF);
        cmp("lw_err", {31'b0, er}, 32'h0);
        cmp("lw_lat", 32'(lat), 32'd2);

        do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'hAAAA_AA55, 0, rd, er, lat);
        cmp("sb_lat", 32'(lat), 32'd3);
        cmp("sb_mem4", mem[4], 32'hDEAD_55EF);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, rd, er, lat);
        cmp("lw_after_sb", rd, 32'hDEAD_55EF);

        do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, rd, er, lat);
        cmp("lb_13_s", rd, 32'hFFFF_FFDE);
        do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, rd, er, lat);
        cmp("lbu_13", rd, 32'h0000_00DE);
        do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 0, rd, er, lat);
        cmp("lh_12_s", rd, 32'hFFFF_DEAD);
        do_req(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 0, rd, er, lat);
        cmp("lhu_10", rd, 32'h0000_55EF);

        do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h1234_BEEF, 0, rd, er, lat);
        cmp("sh_lat", 32'(lat), 32'd3);
        cmp("sh_mem4", mem[4], 32'hBEEF_55EF);
        do_req(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 0, rd, er, lat);
        cmp("lb_11_s", rd, 32'h0000_0055);
        do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 0, rd, er, lat);
        cmp("lb_10_s", rd, 32'hFFFF_FFEF);

        wc = wen_cnt;
        do_req(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 0, rd, er, lat);
        cmp("lw_mis_err", {31'b0, er}, 32'h1);
        cmp("lw_mis_data", rd, 32'h0);
        cmp("lw_mis_lat", 32'(lat), 32'd1);
        do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 0, rd, er, lat);
        cmp("size3_err", {31'b0, er}, 32'h1);
        cmp("size3_lat", 32'(lat), 32'd1);
        do_req(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 0, rd, er, lat);
        cmp("lh_mis_err", {31'b0, er}, 32'h1);
        do_req(1'b1, 2'd2, 1'b0, 32'h12, 32'hFFFF_FFFF, 0, rd, er, lat);
        cmp("sw_mis_err", {31'b0, er}, 32'h1);
        cmp("err_no_write", 32'(wen_cnt - wc), 32'd0);
        cmp("err_mem4", mem[4], 32'hBEEF_55EF);

        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, rd, er, lat);
        cmp("hold_data", rd, 32'hBEEF_55EF);

        // Reset while the sub-word store sits in its read phase.
        wc = wen_cnt;
        req_wen   = 1'b1;
        req_size  = 2'd0;
        req_addr  = 32'h10;
        req_wdata = 32'h77;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        cmp("midrst_req_ready", {31'b0, req_ready}, 32'h1);
        cmp("midrst_mem_wen", {31'b0, mem_wen}, 32'h0);
        step();
        cmp("midrst_no_write", 32'(wen_cnt - wc), 32'd0);
        cmp("midrst_mem4", mem[4], 32'hBEEF_55EF);

        do_req(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 0, rd, er, lat);
`ifdef LSU_BOUNDS_CHECK_EN
        cmp("oob_err", {31'b0, er}, 32'h1);
        cmp("oob_lat", 32'(lat), 32'd1);
`else
        cmp("wrap_err", {31'b0, er}, 32'h0);
        cmp("wrap_data", rd, 32'h1234_5678);
`endif

        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, rd, er, lat);
        cmp("final_lw", rd, 32'hBEEF_55EF);
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
